// File: rtl/spi_pwm_cmd_rx.sv
// SPI mode-0 slave that decodes 8-bit PWM command frames into one-cycle set strobes
// and returns a status byte on MISO. All SPI pins are sampled in the clk domain.
module spi_pwm_cmd_rx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ERR_CNT_W   = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_sck,
    input  logic                 i_cs_n,
    input  logic                 i_mosi,
    output logic                 o_miso,
    output logic                 o_set,
    output logic [2:0]           o_addr,
    output logic [2:0]           o_level,
    output logic                 o_busy,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);

    typedef enum logic {StIdle, StShift} state_t;

    logic [SYNC_STAGES-1:0] r_sck_sync, r_cs_sync, r_mosi_sync;
    logic                   r_sck_last;
    state_t                 r_state, w_state_next;
    logic [2:0]             r_bit_cnt;
    logic [7:0]             r_rx_sr, r_tx_sr;
    logic                   r_done;
    logic                   r_set;
    logic [2:0]             r_addr, r_level;
    logic [2:0]             r_last_addr, r_last_level;
    logic                   r_last_ok;
    logic [ERR_CNT_W-1:0]   r_err_cnt;

    logic                   w_sck, w_cs, w_mosi, w_rise, w_fall;
    logic                   w_start, w_frame_end, w_frame_err;
    logic                   w_par_ok;
    logic [2:0]             w_last_addr_n, w_last_level_n;
    logic                   w_last_ok_n;
    logic [ERR_CNT_W-1:0]   w_err_n;
    logic [7:0]             w_status;

    assign w_sck  = r_sck_sync[SYNC_STAGES-1];
    assign w_cs   = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
    assign w_rise = w_sck & ~r_sck_last;
    assign w_fall = ~w_sck & r_sck_last;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sck_sync  <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sck_last  <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_sck_last  <= w_sck;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_frame_end  = 1'b0;
        w_frame_err  = 1'b0;
        case (r_state)
            StIdle: begin
                if (!w_cs) begin
                    w_state_next = StShift;
                    w_start      = 1'b1;
                end
            end
            StShift: begin
                w_frame_end = w_rise && (r_bit_cnt == 3'd7);
                // An 8th rise coinciding with cs_n release completes the frame normally.
                if (w_cs) begin
                    w_state_next = StIdle;
                    w_frame_err  = (r_bit_cnt != 3'd0) && !w_frame_end;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign w_par_ok = ^r_rx_sr;

    always_comb begin
        w_last_addr_n  = r_last_addr;
        w_last_level_n = r_last_level;
        w_last_ok_n    = r_last_ok;
        w_err_n        = r_err_cnt;
        if (r_done) begin
            if (w_par_ok) begin
                w_last_addr_n  = r_rx_sr[7:5];
                w_last_level_n = r_rx_sr[4:2];
                w_last_ok_n    = 1'b1;
            end else begin
                w_last_ok_n = 1'b0;
            end
        end
        if (w_frame_err) w_last_ok_n = 1'b0;
        if (((r_done && !w_par_ok) || w_frame_err) && (r_err_cnt != '1)) begin
            w_err_n = r_err_cnt + ERR_CNT_W'(1);
        end
    end

    assign w_status = {w_last_addr_n, w_last_level_n, w_last_ok_n, (w_err_n != '0)};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_bit_cnt    <= 3'd0;
            r_rx_sr      <= 8'd0;
            r_tx_sr      <= 8'd0;
            r_done       <= 1'b0;
            r_set        <= 1'b0;
            r_addr       <= 3'd0;
            r_level      <= 3'd0;
            r_last_addr  <= 3'd0;
            r_last_level <= 3'd0;
            r_last_ok    <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            r_state      <= w_state_next;
            r_done       <= w_frame_end;
            r_set        <= r_done && w_par_ok && r_rx_sr[1];
            r_last_addr  <= w_last_addr_n;
            r_last_level <= w_last_level_n;
            r_last_ok    <= w_last_ok_n;
            r_err_cnt    <= w_err_n;
            if (r_done && w_par_ok && r_rx_sr[1]) begin
                r_addr  <= r_rx_sr[7:5];
                r_level <= r_rx_sr[4:2];
            end
            if (r_state == StShift && w_cs) begin
                r_bit_cnt <= 3'd0;
            end else if (r_state == StShift && w_rise) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (r_state == StShift && w_rise) r_rx_sr <= {r_rx_sr[6:0], w_mosi};
            // The fall that closes a frame (bit_cnt already wrapped) must not eat the reload.
            if (w_start || r_done) begin
                r_tx_sr <= w_status;
            end else if (r_state == StShift && w_fall && r_bit_cnt != 3'd0) begin
                r_tx_sr <= {r_tx_sr[6:0], 1'b0};
            end
        end
    end

    assign o_miso    = (r_state == StShift) & r_tx_sr[7];
    assign o_set     = r_set;
    assign o_addr    = r_addr;
    assign o_level   = r_level;
    assign o_busy    = ~w_cs;
    assign o_err_cnt = r_err_cnt;

endmodule
